// File: rtl/mux2_arbiter_pkg.sv
// Shared types and defaults for the two-requester mux arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam int DEFAULT_MAX_HOLD = 8;

endpackage

// File: rtl/mux2_arbiter_if.sv
// Request/grant bundle between the two requesters and the arbiter.
interface mux2_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int CW = $clog2(DEFAULT_MAX_HOLD + 1)
);

  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          sel;
  logic          busy;
  logic          preempt;
  logic [CW-1:0] hold_cnt;

  // requester side
  modport master (
    output req,
    input  gnt, sel, busy, preempt, hold_cnt
  );

  // arbiter side
  modport slave (
    input  req,
    output gnt, sel, busy, preempt, hold_cnt
  );

endinterface

// File: rtl/mux2_arbiter_hold_timer.sv
// Saturating hold counter: clear to 0, load 1 on a new grant, count up while held.
module hold_timer #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          load,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          done
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_HOLD);

  // count cycles of the current grant, saturating at MAX_HOLD
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(1);
    end else if (en && (count != MAX_C)) begin
      count <= count + CW'(1);
    end
  end

  assign done = (count == MAX_C);

endmodule

// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter driving the select of a shared 2:1 mux.
// req is registered once on entry, so a request sampled at one edge shows up
// as a grant after the following edge and nothing combinational reaches gnt.
//
//   state  | meaning
//   IDLE   | no owner; sel keeps the last owner's index
//   GRANT0 | requester 0 owns the mux (sel=0)
//   GRANT1 | requester 1 owns the mux (sel=1)
module mux2_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int CW       = $clog2(MAX_HOLD + 1)
) (
  input  logic           clk,
  input  logic           resetn,
  mux2_arbiter_if.slave  bus
);

  state_t        state;
  state_t        nxt;
  logic [1:0]    req_q;
  logic          last;
  logic          t_clr;
  logic          t_load;
  logic          t_en;
  logic          t_done;
  logic          take_pre;
  logic [CW-1:0] cnt;

  // input register for the requests
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_q <= 2'b00;
    end else begin
      req_q <= bus.req;
    end
  end

  // next-state decision and hold-timer control
  always_comb begin
    nxt      = state;
    take_pre = 1'b0;
    t_clr    = 1'b0;
    t_load   = 1'b0;
    t_en     = 1'b0;
    case (state)
      IDLE: begin
        case (req_q)
          2'b01:   nxt = GRANT0;
          2'b10:   nxt = GRANT1;
          2'b11:   nxt = last ? GRANT0 : GRANT1;
          default: nxt = IDLE;
        endcase
      end
      GRANT0: begin
        if (req_q[0] && !(req_q[1] && t_done)) begin
          nxt = GRANT0;
        end else if (req_q[1]) begin
          nxt      = GRANT1;
          take_pre = req_q[0];
        end else begin
          nxt = IDLE;
        end
      end
      GRANT1: begin
        if (req_q[1] && !(req_q[0] && t_done)) begin
          nxt = GRANT1;
        end else if (req_q[0]) begin
          nxt      = GRANT0;
          take_pre = req_q[1];
        end else begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase

    if (nxt == IDLE) begin
      t_clr = 1'b1;
    end else if (nxt != state) begin
      t_load = 1'b1;
    end else begin
      t_en = 1'b1;
    end
  end

  // state register with registered grant outputs and round-robin pointer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      bus.gnt     <= 2'b00;
      bus.sel     <= 1'b0;
      bus.busy    <= 1'b0;
      bus.preempt <= 1'b0;
      last        <= 1'b1;
    end else begin
      state       <= nxt;
      bus.preempt <= take_pre;
      bus.busy    <= (nxt != IDLE);
      case (nxt)
        GRANT0: begin
          bus.gnt <= 2'b01;
          bus.sel <= 1'b0;
          last    <= 1'b0;
        end
        GRANT1: begin
          bus.gnt <= 2'b10;
          bus.sel <= 1'b1;
          last    <= 1'b1;
        end
        default: begin
          bus.gnt <= 2'b00;
        end
      endcase
    end
  end

  hold_timer #(
    .MAX_HOLD (MAX_HOLD),
    .CW       (CW)
  ) u_hold_timer (
    .clk    (clk),
    .resetn (resetn),
    .clr    (t_clr),
    .load   (t_load),
    .en     (t_en),
    .count  (cnt),
    .done   (t_done)
  );

  assign bus.hold_cnt = cnt;

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles while the other requester waits; legal range 2..255.
REQ-002 Parameter CW, default $clog2(MAX_HOLD+1): hold-counter width.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 req  input  2  req[k]=1: requester k wants the shared 2:1 mux output.
REQ-006 gnt  output  2  one-hot or zero; gnt[k]=1: requester k owns the mux.
REQ-007 sel  output  1  drives mux select s: 0 passes requester 0 (x), 1 passes requester 1 (y).
REQ-008 busy  output  1  1 whenever gnt != 2'b00.
REQ-009 preempt  output  1  one-cycle pulse marking a forced handoff.
REQ-010 hold_cnt  output  CW  cycles the current owner has held the grant.

Function
REQ-011 FSM states: IDLE, GRANT0, GRANT1; all outputs are registered, with no combinational path from req to gnt.
REQ-012 Grant latency: req sampled at edge N; gnt visible after edge N+1 (one cycle).
REQ-013 IDLE, exactly one req high -> GRANTk for that requester.
REQ-014 IDLE, both req high -> grant the requester not granted most recently (round-robin pointer last).
REQ-015 GRANTk, req[k]=1, not preempted -> remain GRANTk; hold_cnt increments, saturating at MAX_HOLD.
REQ-016 GRANTk, req[k]=0, req[other]=1 -> GRANTother next cycle with no idle gap; gnt never 2'b11.
REQ-017 GRANTk, req[k]=0, req[other]=0 -> IDLE.
REQ-018 GRANTk, req[k]=1, req[other]=1, hold_cnt==MAX_HOLD -> GRANTother; preempt=1 for that single cycle.
REQ-019 Owner alone (req[other]=0) is never preempted; hold_cnt saturates at MAX_HOLD and the grant persists.
REQ-020 hold_cnt = 1 in the first cycle of any new grant (including handoffs); 0 in IDLE.
REQ-021 sel = index of current owner; in IDLE sel holds the last owner's index (no glitch on the mux).
REQ-022 last updates to k whenever GRANTk is entered.
REQ-023 A preempted requester keeping req high re-competes normally; it regains the grant via REQ-016 or REQ-018.

Reset
REQ-024 resetn low, asynchronously: state=IDLE, gnt=2'b00, sel=0, busy=0, preempt=0, hold_cnt=0, last=1 (requester 0 wins the first tie).
REQ-025 Reset asserted mid-grant takes effect immediately, with no completion of the current grant.
REQ-026 First grant is possible at the second rising edge after resetn deasserts.

Structure
REQ-027 Package mux_arb_pkg holds the state enum typedef (IDLE, GRANT0, GRANT1) and the default MAX_HOLD constant.
REQ-028 One sub-module, hold_timer: saturating CW-bit counter with clear/load-1 and enable inputs and a done=(count==MAX_HOLD) flag.
REQ-029 mux2_arbiter instantiates hold_timer once; the FSM and round-robin pointer live in mux2_arbiter.
REQ-030 The existing mux2to1 is not instantiated inside the block; sel connects to its s at board level.

Verification
REQ-031 Reset, then req=2'b11 at cycle 1 -> gnt=2'b01, sel=0 after edge 2; hold_cnt=1.
REQ-032 Requester 0 holds, req=2'b01 for 20 cycles -> gnt stays 2'b01, hold_cnt saturates at 8, preempt never 1.
REQ-033 req=2'b11 held continuously, MAX_HOLD=8 -> gnt alternates 01/10 every 8 cycles, preempt pulses at each swap, gnt never 2'b11 or 2'b00.
REQ-034 GRANT0, req changes 2'b11 -> 2'b10 -> gnt=2'b10, sel=1 next cycle, hold_cnt=1, preempt=0.
REQ-035 GRANT1 with hold_cnt=5, resetn pulsed low mid-cycle -> gnt=2'b00, sel=0, hold_cnt=0 immediately, before the next clock edge.
REQ-036 Grant to 1 released to IDLE, then req=2'b11 -> gnt=2'b01 (round-robin), sel stays 1 through IDLE until the grant.
